// File: rtl/m2_nonce_ctrl.sv
// Nonce sequencer for the m2 SHA-256 stage: issues nonces at a fixed round period,
// pairs returned final hash words with their nonces, and queues hits for the host.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch nonce range
// ISSUE | write nonce into header RAM (stalls while in-flight queue is full)
// GO    | launch pulse, push nonce in flight, arm round timer
// WAIT  | round timer running
// DRAIN | last nonce issued, waiting for outstanding results
// DONE  | run complete
module m2_nonce_ctrl #(
  parameter int unsigned ROUND_CYCLES   = 66,
  parameter int unsigned INFLIGHT_DEPTH = 4,
  parameter int unsigned FOUND_DEPTH    = 4
) (
  input  logic        clk_h,
  input  logic        host_break,
  input  logic        start,
  input  logic        start_stop,
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_end,
  input  logic [31:0] target,
  input  logic        hash_valid,
  input  logic [31:0] hash_h7,
  input  logic        found_ready,
  output logic        nonce_wr,
  output logic [31:0] nonce_out,
  output logic        go_m2,
  output logic        found_valid,
  output logic [31:0] found_nonce,
  output logic        found_overflow,
  output logic        err_unexpected,
  output logic [31:0] hashes_cnt,
  output logic        busy,
  output logic        done
);

  localparam int TW  = $clog2(ROUND_CYCLES);
  localparam int IAW = $clog2(INFLIGHT_DEPTH);
  localparam int FAW = $clog2(FOUND_DEPTH);
  localparam logic [TW-1:0] TIMER_INIT = TW'(ROUND_CYCLES - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_GO, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     nonce_cur_q, nonce_cur_d;
  logic [31:0]     end_q, end_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            load_entry;

  logic [31:0]     if_mem [INFLIGHT_DEPTH];
  logic [IAW-1:0]  if_wr_q, if_rd_q;
  logic [IAW:0]    if_cnt_q;
  logic            if_full, if_empty, if_push, if_pop, if_flush;

  logic            hit_q;
  logic [31:0]     hit_nonce_q;

  logic [31:0]     f_mem [FOUND_DEPTH];
  logic [FAW-1:0]  f_wr_q, f_rd_q;
  logic [FAW:0]    f_cnt_q;
  logic            f_full, f_push, f_pop;

  logic            ovf_q, err_q;
  logic [31:0]     hcnt_q;

  assign if_full  = (if_cnt_q == (IAW+1)'(INFLIGHT_DEPTH));
  assign if_empty = (if_cnt_q == '0);
  assign if_flush = !start_stop;
  assign if_push  = (state_q == S_GO);
  assign if_pop   = hash_valid && (state_q != S_IDLE) && !if_empty;

  assign f_full   = (f_cnt_q == (FAW+1)'(FOUND_DEPTH));
  assign f_pop    = found_valid && found_ready;
  // A full FIFO still accepts a hit when the host pops in the same cycle.
  assign f_push   = hit_q && (!f_full || f_pop);

  assign nonce_out      = nonce_cur_q;
  assign found_valid    = (f_cnt_q != '0);
  assign found_nonce    = f_mem[f_rd_q];
  assign found_overflow = ovf_q;
  assign err_unexpected = err_q;
  assign hashes_cnt     = hcnt_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    nonce_cur_d = nonce_cur_q;
    end_d       = end_q;
    timer_d     = timer_q;
    nonce_wr    = 1'b0;
    go_m2       = 1'b0;
    load_entry  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d    = S_LOAD;
        load_entry = 1'b1;
      end
      S_LOAD: begin
        nonce_cur_d = nonce_start;
        end_d       = nonce_end;
        state_d     = S_ISSUE;
      end
      S_ISSUE: if (!if_full) begin
        nonce_wr = 1'b1;
        state_d  = S_GO;
      end
      S_GO: begin
        go_m2   = 1'b1;
        timer_d = TIMER_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q == '0) begin
          if (nonce_cur_q == end_q) begin
            state_d = S_DRAIN;
          end else begin
            nonce_cur_d = nonce_cur_q + 32'd1;
            state_d     = S_ISSUE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DRAIN: if (if_empty && !hash_valid) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (!start_stop) begin
      state_d    = S_IDLE;
      load_entry = 1'b0;
    end
  end

  always_ff @(posedge clk_h or posedge host_break) begin
    if (host_break) begin
      state_q     <= S_IDLE;
      nonce_cur_q <= '0;
      end_q       <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      nonce_cur_q <= nonce_cur_d;
      end_q       <= end_d;
      timer_q     <= timer_d;
    end
  end

  always_ff @(posedge clk_h or posedge host_break) begin
    if (host_break) begin
      for (int i = 0; i < INFLIGHT_DEPTH; i++) if_mem[i] <= '0;
      if_wr_q     <= '0;
      if_rd_q     <= '0;
      if_cnt_q    <= '0;
      hit_q       <= 1'b0;
      hit_nonce_q <= '0;
    end else begin
      hit_q       <= if_pop && (hash_h7 <= target);
      hit_nonce_q <= if_mem[if_rd_q];
      if (if_flush) begin
        if_wr_q  <= '0;
        if_rd_q  <= '0;
        if_cnt_q <= '0;
      end else begin
        if (if_push) begin
          if_mem[if_wr_q] <= nonce_cur_q;
          if_wr_q         <= if_wr_q + IAW'(1);
        end
        if (if_pop) if_rd_q <= if_rd_q + IAW'(1);
        case ({if_push, if_pop})
          2'b10:   if_cnt_q <= if_cnt_q + (IAW+1)'(1);
          2'b01:   if_cnt_q <= if_cnt_q - (IAW+1)'(1);
          default: if_cnt_q <= if_cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_h or posedge host_break) begin
    if (host_break) begin
      for (int i = 0; i < FOUND_DEPTH; i++) f_mem[i] <= '0;
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      if (f_push) begin
        f_mem[f_wr_q] <= hit_nonce_q;
        f_wr_q        <= f_wr_q + FAW'(1);
      end
      if (f_pop) f_rd_q <= f_rd_q + FAW'(1);
      case ({f_push, f_pop})
        2'b10:   f_cnt_q <= f_cnt_q + (FAW+1)'(1);
        2'b01:   f_cnt_q <= f_cnt_q - (FAW+1)'(1);
        default: f_cnt_q <= f_cnt_q;
      endcase
      if (load_entry) begin
        ovf_q  <= 1'b0;
        err_q  <= 1'b0;
        hcnt_q <= '0;
      end else begin
        if (hit_q && f_full && !f_pop) ovf_q <= 1'b1;
        if (hash_valid && (state_q != S_IDLE) && if_empty) err_q <= 1'b1;
        if (if_pop) hcnt_q <= hcnt_q + 32'd1;
      end
    end
  end

endmodule

// File: doc/m2_nonce_ctrl.md
Name: m2_nonce_ctrl

Overview:
- Nonce sequencer and result checker for the m2 SHA-256 stage.
- Writes each nonce into the m2 header RAM, then issues a go_m2 pulse every ROUND_CYCLES.
- Tracks issued nonces in an in-flight queue and pairs each returned final word with its nonce.
- Pushes nonces whose word is <= target into a found FIFO that the host drains over a valid/ready handshake.

Parameters:
- ROUND_CYCLES, 66: clock cycles between successive go_m2 pulses. Must be >= 4.
- INFLIGHT_DEPTH, 4: in-flight nonce queue depth. Power of 2.
- FOUND_DEPTH, 4: found-nonce FIFO depth. Power of 2.

Ports:
- clk_h  in  1  core clock
- host_break  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- start_stop  in  1  run enable level; low aborts the run
- nonce_start  in  32  first nonce; sampled in LOAD
- nonce_end  in  32  last nonce, inclusive; sampled in LOAD
- target  in  32  unsigned threshold
- hash_valid  in  1  one-cycle pulse; hash_h7 valid
- hash_h7  in  32  final hash word from the m2 datapath
- found_ready  in  1  host accepts found_nonce
- nonce_wr  out  1  write nonce_out into the header RAM nonce slot
- nonce_out  out  32  current nonce
- go_m2  out  1  launch pulse to m2_sm
- found_valid  out  1  found FIFO not empty
- found_nonce  out  32  FIFO head
- found_overflow  out  1  sticky: a hit was dropped because the found FIFO was full
- err_unexpected  out  1  sticky: hash_valid arrived with an empty in-flight queue while not IDLE
- hashes_cnt  out  32  count of results consumed; wraps at 2^32
- busy  out  1  state is not IDLE or DONE
- done  out  1  run completed

Behaviour:
- Reset (host_break high, asynchronous) clears everything:
  - all outputs 0, state IDLE;
  - both queues emptied, all counters 0, sticky flags 0.
- Any state with start_stop low goes to IDLE on the next edge:
  - in-flight queue is flushed;
  - found FIFO, hashes_cnt and sticky flags are kept.
- State machine:
  - IDLE, DONE: start & start_stop -> LOAD. Entering LOAD clears done, found_overflow, err_unexpected and hashes_cnt. The found FIFO is not cleared.
  - LOAD (1 cycle): nonce_cur <= nonce_start; end_r <= nonce_end -> ISSUE.
  - ISSUE: if the in-flight queue is not full, assert nonce_wr with nonce_out = nonce_cur -> GO. Otherwise stall in ISSUE with nonce_wr = 0.
  - GO (1 cycle): go_m2 = 1; push nonce_cur into the in-flight queue; timer <= ROUND_CYCLES-3 -> WAIT.
  - WAIT: decrement timer. When timer == 0:
    - if nonce_cur == end_r -> DRAIN;
    - else nonce_cur <= nonce_cur + 1 (mod 2^32) -> ISSUE.
  - DRAIN: when the in-flight queue is empty and no hash_valid is in the current cycle -> DONE, done = 1.
- Issue period with no stall: go_m2 pulses exactly ROUND_CYCLES apart.
- nonce_out holds nonce_cur in every state. nonce_wr precedes go_m2 by exactly 1 cycle.
- Range rules:
  - nonce_end < nonce_start wraps through 0xFFFFFFFF -> 0x00000000;
  - nonce_end == nonce_start issues exactly one nonce.
- Result path:
  - on hash_valid (state not IDLE, queue not empty): pop the head nonce, hashes_cnt++, register hit = (hash_h7 <= target) with the nonce;
  - on the next edge, a hit pushes into the found FIFO; found_valid is high 2 edges after the hash_valid edge;
  - in IDLE, hash_valid is ignored;
  - in other states with an empty queue: ignored and err_unexpected set.
- Simultaneous events:
  - in-flight push (GO) and pop (hash_valid) in the same cycle are both performed; occupancy is unchanged;
  - found FIFO push and pop (found_valid & found_ready) in the same cycle are both performed, even when the FIFO is full;
  - a hit with the FIFO full and no pop is dropped and found_overflow is set.
- found_nonce is the registered FIFO head. Data is stable while found_valid & !found_ready.

Test Plan:
- Basic range: ROUND_CYCLES=66, nonce_start=0x10, nonce_end=0x12, target=0; hash_valid 40 cycles after each go_m2 with hash_h7=1 -> exactly 3 go_m2 pulses, 66 apart, nonce_out 0x10, 0x11, 0x12; nonce_wr 1 cycle before each go_m2; no hits; done=1; hashes_cnt=3.
- Hit pairing: same run with target=0x0000FFFF; hash_h7 = 0x00010000, 0x0000FFFF, 0x00000000 -> found FIFO holds 0x11 then 0x12; found_valid rises 2 cycles after the second hash_valid.
- Wrap and single: nonce_start=0xFFFFFFFE, nonce_end=0x1 -> nonces FFFFFFFE, FFFFFFFF, 0, 1. nonce_start = nonce_end = 0x5 -> one go_m2, then done.
- Back-pressure: INFLIGHT_DEPTH=4, no hash_valid returned -> 4 go_m2 pulses, then ISSUE stalls with nonce_wr=0; one hash_valid -> exactly one further nonce_wr/go_m2 pair.
- Overflow: FOUND_DEPTH=4, found_ready=0, target=0xFFFFFFFF, 6 nonces -> 4 entries held (first four nonces), found_overflow=1. Raise found_ready -> entries drain in order.
- Abort and reset:
  - start_stop low mid-WAIT -> IDLE next cycle, go_m2 stops, later hash_valid ignored, err_unexpected stays 0;
  - host_break asserted asynchronously mid-run -> all outputs 0 before the next clk_h edge.
